// File: rtl/mem_display_reader.sv
// Fetches an item count, then one result word per debounced press; shows its low 16 bits as hex on a 4-digit mux display.
// Count ready 2 cycles after reset with grant held; reads stall in *_REQ while bus_grant is low, and presses outside IDLE are dropped.
module mem_display_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned SCAN_CYCLES     = 50000,
    parameter logic [31:0] COUNT_ADDR      = 32'h0000_0000,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic        bus_grant,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [11:0] leds
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [2:0] {CNT_REQ, CNT_CAP, IDLE, DAT_REQ, DAT_CAP} state_t;

    logic            sync0, sync1, deb, deb_q, press;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync0 <= button;
            sync1 <= sync0;
            deb_q <= deb;
            if (sync1 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb    <= sync1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = deb & ~deb_q;

    state_t      state, state_nxt;
    logic [31:0] idx, count, dat_addr;
    logic [15:0] display;

    assign dat_addr = BASE_ADDR + {idx[29:0], 2'b00};
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_addr  = COUNT_ADDR;
        case (state)
            CNT_REQ: begin
                mem_read = bus_grant;
                if (bus_grant) state_nxt = CNT_CAP;
            end
            CNT_CAP: begin
                mem_read  = 1'b1;
                state_nxt = IDLE;
            end
            IDLE: begin
                if (press && (idx < count)) state_nxt = DAT_REQ;
            end
            DAT_REQ: begin
                mem_addr = dat_addr;
                mem_read = bus_grant;
                if (bus_grant) state_nxt = DAT_CAP;
            end
            DAT_CAP: begin
                mem_addr  = dat_addr;
                mem_read  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = CNT_REQ;
        endcase
        // Keep the strobe quiet while reset is held, whatever bus_grant does.
        if (!reset) begin
            mem_read = 1'b0;
            mem_addr = COUNT_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= CNT_REQ;
            idx     <= '0;
            count   <= '0;
            display <= '0;
        end else begin
            state <= state_nxt;
            if (state == CNT_CAP) count <= mem_rdata;
            if (state == IDLE && press && !(idx < count)) display <= 16'h0000;
            if (state == DAT_CAP) begin
                display <= mem_rdata[15:0];
                idx     <= idx + 32'd1;
            end
        end
    end

    logic [DIV_W-1:0] div;
    logic [1:0]       digit;
    logic [3:0]       nib;
    logic [6:0]       seg;

    assign nib = display[{digit, 2'b00} +: 4];

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div   <= '0;
            digit <= 2'd0;
            leds  <= 12'hEC0;
        end else begin
            if (div == DIV_W'(SCAN_CYCLES - 1)) begin
                div   <= '0;
                digit <= digit + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            leds <= {~(4'b0001 << digit), 1'b1, seg};
        end
    end

endmodule

// File: tb/tb_mem_display_reader.sv
// Scoreboard bench: expected read addresses are queued as presses are driven and popped as the DUT strobes mem_read.
module tb_mem_display_reader;

    logic        clk = 1'b0;
    logic        reset, button, bus_grant;
    logic        mem_read;
    logic [31:0] mem_addr, mem_rdata;
    logic        busy;
    logic [11:0] leds;

    logic [31:0] mem [0:15];
    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_len = 0;
    logic        mr_prev = 1'b0;
    bit          len_chk = 1'b1;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    mem_display_reader #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES    (2),
        .COUNT_ADDR     (32'h0000_0000),
        .BASE_ADDR      (32'h0000_0014)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .bus_grant(bus_grant),
        .mem_read (mem_read),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .leds     (leds)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    function automatic logic [11:0] mk_leds(input logic [1:0] d, input logic [15:0] v);
        logic [3:0] an;
        logic [3:0] n;
        an = ~(4'b0001 << d);
        n  = 4'(v >> (4 * d));
        return {an, 1'b1, seg_of(n)};
    endfunction

    function automatic logic [1:0] dec(input logic [11:0] l);
        case (l[11:8])
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_read && !mr_prev) begin
            chk("rd_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("rd_addr", mem_addr, exp_q.pop_front());
        end
        if (mem_read) begin
            rd_len++;
        end else if (mr_prev) begin
            if (len_chk) chk("rd_len", rd_len, 2);
            rd_len = 0;
        end
        mr_prev = mem_read;
    end

    task automatic press_btn();
        button = 1'b1;
        tick(12);
        button = 1'b0;
        tick(12);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        bus_grant = 1'b1;
        tick(3);
        exp_q.push_back(32'h0);
        reset = 1'b1;
        tick(4);
    endtask

    task automatic check_display(input logic [15:0] v);
        logic [3:0] seen;
        logic [1:0] d;
        seen = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d = dec(leds);
            seen[d] = 1'b1;
            chk("disp", 32'(leds), 32'(mk_leds(d, v)));
        end
        chk("disp_cover", 32'(seen), 32'hF);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic       found;
        logic [1:0] d0, prev;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'd3; mem[5] = 32'd24; mem[6] = 32'd1; mem[7] = 32'h0000_BEEF;
        reset = 1'b0; button = 1'b0; bus_grant = 1'b1;

        // Reset state and count fetch
        tick(3);
        @(negedge clk);
        chk("rst_leds", 32'(leds), 32'hEC0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd", 32'(mem_read), 32'd0);
        exp_q.push_back(32'h0);
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        chk("cnt_req_rd", 32'(mem_read), 32'd1);
        chk("cnt_req_addr", mem_addr, 32'h0);
        tick(1); @(negedge clk);
        chk("cnt_cap_rd", 32'(mem_read), 32'd1);
        chk("cnt_cap_busy", 32'(busy), 32'd1);
        tick(1); @(negedge clk);
        chk("idle_rd", 32'(mem_read), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Stepping through the three items, then past the end
        exp_q.push_back(32'h14); press_btn(); check_display(16'h0018);
        exp_q.push_back(32'h18); press_btn(); check_display(16'h0001);
        exp_q.push_back(32'h1C); press_btn(); check_display(16'hBEEF);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (leds[11:8] == 4'b1110) found = 1'b1;
        end
        chk("beef_d0", 32'(leds), 32'hE8E);
        press_btn();
        check_display(16'h0000);
        chk("end_busy", 32'(busy), 32'd0);

        // Grant stall during count fetch
        reset = 1'b0; bus_grant = 1'b0;
        tick(3);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rd", 32'(mem_read), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            tick(1);
        end
        exp_q.push_back(32'h0);
        bus_grant = 1'b1;
        tick(2); @(negedge clk);
        chk("stall_done", 32'(busy), 32'd0);

        // Debounce: short pulses rejected, held button gives one read
        for (int w = 1; w <= 3; w++) begin
            button = 1'b1; tick(w);
            button = 1'b0; tick(10);
        end
        @(negedge clk);
        chk("bounce_busy", 32'(busy), 32'd0);
        chk("bounce_q", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(32'h14);
        button = 1'b1; tick(100);
        button = 1'b0; tick(12);
        chk("held_q", 32'(exp_q.size()), 32'd0);
        check_display(16'h0018);

        // Press dropped while stalled in DAT_REQ
        do_reset();
        bus_grant = 1'b0;
        button = 1'b1; tick(12);
        @(negedge clk);
        chk("dreq_busy", 32'(busy), 32'd1);
        chk("dreq_rd", 32'(mem_read), 32'd0);
        button = 1'b0; tick(12);
        press_btn();
        exp_q.push_back(32'h14);
        bus_grant = 1'b1;
        tick(5); @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd0);
        check_display(16'h0018);
        tick(30);
        chk("drop_q", 32'(exp_q.size()), 32'd0);

        // Reset asserted in DAT_CAP
        bus_grant = 1'b0;
        press_btn();
        exp_q.push_back(32'h18);
        len_chk = 1'b0;
        bus_grant = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3); @(negedge clk);
        chk("midrst_leds", 32'(leds), 32'hEC0);
        chk("midrst_busy", 32'(busy), 32'd1);
        len_chk = 1'b1;
        exp_q.push_back(32'h0);
        tick(1);
        reset = 1'b1;
        tick(4);
        check_display(16'h0000);
        exp_q.push_back(32'h14);
        press_btn();
        check_display(16'h0018);

        // Scan sequence with 0x1234
        mem[5] = 32'h0000_1234;
        do_reset();
        exp_q.push_back(32'h14);
        press_btn();
        @(negedge clk);
        prev = dec(leds);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (dec(leds) != prev) found = 1'b1;
        end
        chk("scan_sync", 32'(found), 32'd1);
        d0 = dec(leds);
        for (int i = 0; i < 16; i++) begin
            chk("scan_seq", 32'(leds), 32'(mk_leds(2'(d0 + 2'(i / 2)), 16'h1234)));
            @(negedge clk);
        end

        tick(4);
        chk("final_q", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
